// File: rtl/feature_wr_pkg.sv
// Shared types and AXI constants for the HOG feature write controller.
package feature_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wr_state_t;

  localparam logic [2:0] AWSIZE_64B = 3'd6;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BEAT_BYTES      = 1 << AWSIZE_64B;
  localparam int unsigned BURST_BYTES     = 16 * BEAT_BYTES;
  localparam int unsigned BASE_ALIGN_BITS = 10;

endpackage

// File: rtl/feature_beat_buf.sv
// One-entry hold register between the feature reader and the AXI W channel.
module feature_beat_buf #(
  parameter int unsigned DW = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          pop,
  output logic [DW-1:0] data,
  output logic          full,
  output logic          ovf
);

  logic accept;

  // A load coinciding with a pop replaces the departing beat and keeps the entry full.
  assign accept = load && (!full || pop);
  assign ovf    = load && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else if (accept) begin
      data <= load_data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/feature_axi_write_ctrl.sv
// Drives the HOG result-feature readout and streams it to DDR as fixed-length AXI4 INCR bursts.
module feature_axi_write_ctrl
  import feature_wr_pkg::*;
#(
  parameter int unsigned AXI_DW      = 512,
  parameter int unsigned AXI_AW      = 32,
  parameter int unsigned BURST_LEN   = BURST_BYTES / BEAT_BYTES,
  parameter int unsigned TOTAL_BEATS = 1984
) (
  input  logic                aclk,
  input  logic                arest_n,
  input  logic                cfg_start,
  input  logic [AXI_AW-1:0]   cfg_base_addr,
  output logic                busy,
  output logic                err_bresp,
  output logic                err_ovf,
  output logic                res_start,
  output logic                w_handshake,
  output logic                wr_done,
  input  logic [AXI_DW-1:0]   res_data,
  input  logic                res_data_valid,
  output logic [AXI_AW-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [AXI_DW-1:0]   m_wdata,
  output logic [AXI_DW/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int unsigned NUM_BURSTS = TOTAL_BEATS / BURST_LEN;
  localparam int unsigned BEAT_W     = $clog2(TOTAL_BEATS);
  localparam int unsigned BURST_W    = $clog2(NUM_BURSTS);
  localparam int unsigned BIB_W      = $clog2(BURST_LEN);

  localparam logic [AXI_AW-1:0] STRIDE     = AXI_AW'(BURST_LEN * BEAT_BYTES);
  localparam logic [AXI_AW-1:0] ALIGN_MASK = AXI_AW'((1 << BASE_ALIGN_BITS) - 1);

  wr_state_t state, state_nxt;

  logic [AXI_AW-1:0]  base_q;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BIB_W-1:0]   beat_in_burst;

  logic res_start_q, w_hs_q, err_bresp_q, err_ovf_q;
  logic start_acc, w_fire, b_fire;
  logic last_in_burst, last_beat, last_burst;

  logic              buf_full, buf_ovf;
  logic [AXI_DW-1:0] buf_data;

  feature_beat_buf #(.DW(AXI_DW)) u_beat_buf (
    .clk       (aclk),
    .rst_n     (arest_n),
    .load      (res_data_valid),
    .load_data (res_data),
    .pop       (w_fire),
    .data      (buf_data),
    .full      (buf_full),
    .ovf       (buf_ovf)
  );

  assign start_acc     = (state == ST_IDLE) && cfg_start;
  assign w_fire        = (state == ST_DATA) && buf_full && m_wready;
  assign b_fire        = (state == ST_RESP) && m_bvalid;
  assign last_in_burst = beat_in_burst == BIB_W'(BURST_LEN - 1);
  assign last_beat     = beat_cnt == BEAT_W'(TOTAL_BEATS - 1);
  assign last_burst    = burst_cnt == BURST_W'(NUM_BURSTS - 1);

  always_ff @(posedge aclk) begin
    if (!arest_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_wvalid  = 1'b0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    busy      = 1'b0;
    wr_done   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cfg_start) state_nxt = ST_AW;
      end
      ST_AW: begin
        busy      = 1'b1;
        m_awvalid = 1'b1;
        m_awaddr  = base_q + AXI_AW'(burst_cnt) * STRIDE;
        m_awlen   = 8'(BURST_LEN - 1);
        m_awsize  = AWSIZE_64B;
        m_awburst = BURST_INCR;
        if (m_awready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        busy     = 1'b1;
        m_wvalid = buf_full;
        m_wstrb  = '1;
        m_wlast  = last_in_burst;
        if (w_fire && last_in_burst) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        busy     = 1'b1;
        m_bready = 1'b1;
        if (m_bvalid) state_nxt = last_burst ? ST_DONE : ST_AW;
      end
      ST_DONE: begin
        wr_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reader launches are registered so each one follows the handshake that freed the buffer.
  always_ff @(posedge aclk) begin
    if (!arest_n) begin
      base_q        <= '0;
      beat_cnt      <= '0;
      burst_cnt     <= '0;
      beat_in_burst <= '0;
      res_start_q   <= 1'b0;
      w_hs_q        <= 1'b0;
      err_bresp_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      res_start_q <= start_acc;
      w_hs_q      <= w_fire && !last_beat;
      if (start_acc) begin
        base_q        <= cfg_base_addr & ~ALIGN_MASK;
        beat_cnt      <= '0;
        burst_cnt     <= '0;
        beat_in_burst <= '0;
        err_bresp_q   <= 1'b0;
        err_ovf_q     <= 1'b0;
      end else begin
        if (w_fire) begin
          beat_cnt      <= last_beat ? '0 : beat_cnt + 1'b1;
          beat_in_burst <= last_in_burst ? '0 : beat_in_burst + 1'b1;
        end
        if (b_fire) begin
          if (m_bresp != RESP_OKAY) err_bresp_q <= 1'b1;
          burst_cnt <= last_burst ? '0 : burst_cnt + 1'b1;
        end
        if (buf_ovf) err_ovf_q <= 1'b1;
      end
    end
  end

  assign res_start   = res_start_q;
  assign w_handshake = w_hs_q;
  assign err_bresp   = err_bresp_q;
  assign err_ovf     = err_ovf_q;
  assign m_wdata     = buf_data;

endmodule

// File: tb/tb_feature_axi_write_ctrl.sv
// Directed frame sequence with a randomized reader/slave environment and an in-bench frame model.
module tb_feature_axi_write_ctrl;

  localparam int unsigned DW     = 512;
  localparam int unsigned AW     = 32;
  localparam int unsigned BL     = 16;
  localparam int unsigned TB     = 1984;
  localparam int unsigned NBURST = TB / BL;
  localparam int          LIMIT  = 25000;

  logic            aclk = 1'b0;
  logic            arest_n;
  logic            cfg_start;
  logic [AW-1:0]   cfg_base_addr;
  logic            busy, err_bresp, err_ovf, res_start, w_handshake, wr_done;
  logic [DW-1:0]   res_data;
  logic            res_data_valid;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wlast, m_wvalid, m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;

  always #5 aclk = ~aclk;

  feature_axi_write_ctrl #(
    .AXI_DW      (DW),
    .AXI_AW      (AW),
    .BURST_LEN   (BL),
    .TOTAL_BEATS (TB)
  ) dut (
    .aclk           (aclk),
    .arest_n        (arest_n),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .busy           (busy),
    .err_bresp      (err_bresp),
    .err_ovf        (err_ovf),
    .res_start      (res_start),
    .w_handshake    (w_handshake),
    .wr_done        (wr_done),
    .res_data       (res_data),
    .res_data_valid (res_data_valid),
    .m_awaddr       (m_awaddr),
    .m_awlen        (m_awlen),
    .m_awsize       (m_awsize),
    .m_awburst      (m_awburst),
    .m_awvalid      (m_awvalid),
    .m_awready      (m_awready),
    .m_wdata        (m_wdata),
    .m_wstrb        (m_wstrb),
    .m_wlast        (m_wlast),
    .m_wvalid       (m_wvalid),
    .m_wready       (m_wready),
    .m_bresp        (m_bresp),
    .m_bvalid       (m_bvalid),
    .m_bready       (m_bready)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reader beat k of a frame: every 32-bit word tags the frame salt, the word index and k.
  function automatic logic [DW-1:0] pat(input int unsigned s, input int unsigned k);
    logic [DW-1:0] p;
    for (int w = 0; w < int'(DW / 32); w++) p[w*32 +: 32] = s ^ {8'(w), 24'(k)};
    return p;
  endfunction

  // Frame configuration and observation counters shared by main sequence and environment.
  int unsigned salt;
  logic [31:0] exp_base, first_awaddr;
  int          lat, err_burst;
  bit          rnd, stall_w, spur_req, spur_done;
  int          n_aw, n_w, n_wh, n_rs, n_done, n_b;

  int          rd_cd, rd_idx, b_owed;
  bit          b_fire, prev_aw_stall, prev_w_stall, prev_wlast;
  logic [31:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;

  // Reader model, AXI slave and monitor, all evaluated 1 time unit after each rising edge.
  initial begin
    res_data_valid = 1'b0; res_data = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    rd_cd = 0; rd_idx = 0; b_owed = 0; b_fire = 0;
    prev_aw_stall = 0; prev_w_stall = 0; prev_wlast = 0; prev_awaddr = '0; prev_wdata = '0;
    forever begin
      @(posedge aclk); #1;
      res_data_valid = 1'b0;
      if (b_fire) begin m_bvalid = 1'b0; b_fire = 0; end
      if (!arest_n) begin
        rd_cd = 0; b_owed = 0; m_bvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0;
        prev_aw_stall = 0; prev_w_stall = 0;
        continue;
      end

      if (wr_done) n_done++;
      if (res_start || w_handshake) begin
        chk32("launch_outstanding", rd_cd, 0);
        if (res_start) begin n_rs++; rd_idx = 0; end
        else begin n_wh++; rd_idx++; end
        rd_cd = lat;
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin res_data_valid = 1'b1; res_data = pat(salt, rd_idx); end
      end
      if (spur_req && stall_w && m_wvalid) begin
        res_data_valid = 1'b1;
        res_data = {16{$urandom()}};
        spur_req = 0; spur_done = 1;
      end

      if (!m_bvalid && b_owed > 0 && (!rnd || $urandom_range(0, 9) < 3)) begin
        m_bvalid = 1'b1;
        m_bresp  = (n_b == err_burst) ? 2'b10 : 2'b00;
      end
      if (m_bvalid && m_bready) begin n_b++; b_owed--; b_fire = 1; end

      m_awready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (prev_aw_stall) begin
        chk32("awvalid_held", 32'(m_awvalid), 1);
        chk32("awaddr_stable", m_awaddr, prev_awaddr);
      end
      if (m_awvalid && m_awready) begin
        if (n_aw == 0) first_awaddr = m_awaddr;
        chk32("awaddr", m_awaddr, exp_base + 32'(n_aw) * 32'd1024);
        chk32("aw_len_size_burst", {21'd0, m_awlen, m_awsize}, {21'd0, 8'd15, 3'd6});
        chk32("awburst", 32'(m_awburst), 1);
        n_aw++;
      end
      prev_aw_stall = m_awvalid && !m_awready;
      prev_awaddr   = m_awaddr;

      m_wready = stall_w ? 1'b0 : (rnd ? ($urandom_range(0, 9) < 3) : 1'b1);
      if (prev_w_stall) begin
        chk32("wvalid_held", 32'(m_wvalid), 1);
        chkw("wdata_stable", m_wdata, prev_wdata);
        chk32("wlast_stable", 32'(m_wlast), 32'(prev_wlast));
      end
      if (m_wvalid && m_wready) begin
        chkw("wdata", m_wdata, pat(salt, n_w));
        chkw("wstrb", DW'(m_wstrb), DW'({(DW/8){1'b1}}));
        chk32("wlast", 32'(m_wlast), 32'(n_w % BL == BL - 1));
        if (m_wlast) b_owed++;
        n_w++;
      end
      prev_w_stall = m_wvalid && !m_wready;
      prev_wdata   = m_wdata;
      prev_wlast   = m_wlast;
    end
  end

  task automatic check_outputs_zero();
    chk32("rst_ctrl_outputs",
          32'({m_awvalid, m_wvalid, m_wlast, m_bready, busy, wr_done,
               res_start, w_handshake, err_bresp, err_ovf}), 0);
    chk32("rst_awaddr", m_awaddr, 0);
    chk32("rst_aw_fields", {19'd0, m_awlen, m_awsize, m_awburst}, 0);
    chkw("rst_wdata", m_wdata, '0);
    chkw("rst_wstrb", DW'(m_wstrb), '0);
  endtask

  task automatic start_frame(input logic [31:0] base, input int l, input bit r, input int eb);
    @(negedge aclk);
    n_aw = 0; n_w = 0; n_wh = 0; n_rs = 0; n_done = 0; n_b = 0;
    salt = $urandom(); lat = l; rnd = r; err_burst = eb;
    exp_base = base & 32'hFFFF_FC00;
    cfg_base_addr = base;
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    chk32("res_start_pulse", 32'(res_start), 1);
    chk32("busy_on_start", 32'(busy), 1);
    chk32("err_cleared_on_start", 32'({err_bresp, err_ovf}), 0);
  endtask

  task automatic finish_frame();
    for (int c = 0; c < LIMIT && n_done == 0; c++) @(negedge aclk);
    repeat (5) @(negedge aclk);
    chk32("wr_done_count", n_done, 1);
    chk32("busy_after_done", 32'(busy), 0);
    chk32("aw_count", n_aw, NBURST);
    chk32("w_count", n_w, TB);
    chk32("w_handshake_count", n_wh, TB - 1);
    chk32("res_start_count", n_rs, 1);
    chk32("b_count", n_b, NBURST);
  endtask

  task automatic wait_beats(input int target);
    for (int c = 0; c < LIMIT && n_w < target; c++) @(negedge aclk);
    chk32("reached_beat", 32'(n_w >= target), 1);
  endtask

  initial begin
    arest_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0;
    stall_w = 0; spur_req = 0; spur_done = 0;
    salt = 0; exp_base = '0; first_awaddr = '0; lat = 1; rnd = 0; err_burst = -1;
    n_aw = 0; n_w = 0; n_wh = 0; n_rs = 0; n_done = 0; n_b = 0;
    repeat (3) @(negedge aclk);
    check_outputs_zero();
    arest_n = 1'b1;
    repeat (2) @(negedge aclk);

    // Frame A: aligned base, always-ready slave, 4-cycle reader, extra cfg_start mid-frame.
    start_frame(32'h8000_0000, 4, 1'b0, -1);
    wait_beats(100);
    cfg_base_addr = 32'h4000_0000;
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    finish_frame();
    chk32("frameA_errs", 32'({err_bresp, err_ovf}), 0);
    repeat (10) @(negedge aclk);
    chk32("no_restart_aw", n_aw, NBURST);
    chk32("no_restart_res_start", n_rs, 1);
    chk32("idle_busy", 32'(busy), 0);

    // Frame B: unaligned base, 30% ready duty, SLVERR on burst 5.
    start_frame(32'h1234_5678, 1, 1'b1, 5);
    finish_frame();
    chk32("first_awaddr_aligned", first_awaddr, 32'h1234_5400);
    chk32("err_bresp_sticky", 32'(err_bresp), 1);
    chk32("frameB_err_ovf", 32'(err_ovf), 0);

    // Frame C: spurious reader beat while stalled, then reset at beat 700.
    start_frame($urandom(), 1, 1'b0, -1);
    wait_beats(100);
    stall_w = 1; spur_req = 1; spur_done = 0;
    for (int c = 0; c < 200 && !spur_done; c++) @(negedge aclk);
    repeat (3) @(negedge aclk);
    chk32("spur_injected", 32'(spur_done), 1);
    chk32("err_ovf_set", 32'(err_ovf), 1);
    chk32("held_beat_valid", 32'(m_wvalid), 1);
    stall_w = 0; spur_req = 0;
    wait_beats(700);
    arest_n = 1'b0;
    @(posedge aclk); #2;
    check_outputs_zero();
    repeat (2) @(negedge aclk);
    arest_n = 1'b1;
    repeat (20) @(negedge aclk);
    chk32("no_wr_done_after_abort", n_done, 0);
    chk32("idle_after_abort", 32'(busy), 0);

    // Frame D: clean frame after the abort.
    start_frame($urandom(), 1, 1'b0, -1);
    finish_frame();
    chk32("frameD_errs", 32'({err_bresp, err_ovf}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
